alu_out_stage: RTL and testbench
================================

# alu_out_stage

Registered, flow-controlled result selector for the ALU datapath. Takes the packed results of all NOPS operation units plus a one-hot select, picks one result, derives zero/negative flags, and flags illegal selects. Adds a valid/ready handshake with a two-entry skid buffer so the ALU can sit in a stalling pipeline. Sits between the operation units (and, or, xor, not, add, sub, mult) and the writeback stage.

## Interface

- WIDTH, 8, result width in bits (≥2)
- NOPS, 7, number of operation inputs (≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream presents res_bus/sel
- in_ready  out  1  stage can accept this cycle
- res_bus  in  NOPS*WIDTH  packed results; op i at [i*WIDTH +: WIDTH]
- sel  in  NOPS  one-hot operation select; bit i picks op i
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  selected result
- out_zero  out  1  out_data == 0
- out_neg  out  1  out_data[WIDTH-1]
- out_sel_err  out  1  sel was not one-hot for this word
- err_count  out  8  saturating count of accepted illegal selects

Reset is synchronous and active-low on rst_n; single clock clk.

## Operation

- Accept when in_valid && in_ready; transfer out when out_valid && out_ready.
- Selected word: OR of res_bus slices gated by sel bits. If popcount(sel) != 1 (zero or multiple bits): data forced to 0, sel_err=1, out_zero=1, out_neg=0. Word is still forwarded, never dropped.
- Flags computed from the stored data, registered with it; never recomputed at output.
- err_count increments by 1 on each accepted word with sel_err; saturates at 255, never wraps. Cleared only by reset.
- Storage: output register (OREG) plus skid register (SREG). FSM states:
  - EMPTY: out_valid=0. Accept → OREG, go FULL1.
  - FULL1: out_valid=1. Accept without transfer → SREG, go FULL2. Transfer without accept → EMPTY. Both → OREG reloaded, stay FULL1.
  - FULL2: out_valid=1, in_ready=0. Transfer → SREG moves to OREG, go FULL1.
- in_ready = rst_n && (state != FULL2); registered-state-derived only, no combinational path from out_ready.
- Order strictly preserved; no word duplicated or lost.

## Timing

- Latency: word accepted at edge N is on out_data after edge N (visible cycle N+1) when stage was EMPTY, or FULL1 with simultaneous transfer.
- Throughput: one word/cycle with out_ready held high.
- Reset (rst_n low at an edge): state EMPTY, out_valid=0, out_data=0, out_zero=0, out_neg=0, out_sel_err=0, err_count=0; in_ready=0 while rst_n low. Reset mid-operation discards both buffered words.
- out_data/flags held stable while out_valid && !out_ready.
- in_valid low: in_ready still reflects capacity; contents unaffected.

## Structure

- Shared package alu_pkg: op index constants OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOT=3, OP_ADD=4, OP_SUB=5, OP_MULT=6; default NOPS=7; FSM state enum {EMPTY, FULL1, FULL2}; ERR_CNT_W=8.
- One sub-module: onehot_sel_mux (combinational; WIDTH, NOPS parameters; outputs selected data and illegal flag). Top holds FSM, OREG/SREG, flags, counter.

## Test plan

- Reset then sel=7'b0010000, add slice=8'h80, out_ready=1 → next cycle out_data=8'h80, out_neg=1, out_zero=0, out_sel_err=0.
- sel=7'b0000011 (and=8'h0F, or=8'hFF) → out_data=8'h00, out_zero=1, out_sel_err=1, err_count=1.
- out_ready=0, three back-to-back words A,B,C → A on output, B in skid, in_ready=0 on C's cycle, C not accepted; release out_ready → A, B, C emerge in order, one per cycle.
- 300 accepted sel=0 words → err_count stops at 255.
- Continuous in_valid/out_ready=1 with rotating sel over all 7 ops → one result/cycle, each matching its slice, flags correct.
- rst_n low one cycle while FULL2 → out_valid=0, err_count=0, in_ready=0 during reset, 1 the cycle after.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation slot indices, stage FSM states, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // Slot index of each operation unit inside the packed result bus
    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NOT  = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_SUB  = 5;
    localparam int OP_MULT = 6;

    localparam int NOPS_DEFAULT = 7;
    localparam int ERR_CNT_W    = 8;

    // Occupancy of the output stage: nothing, output register only, output + skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_sel_mux.sv
// One-hot result selector: ORs the slices picked by sel, flags non-one-hot selects.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
module onehot_sel_mux #(
    parameter int WIDTH = 8,
    parameter int NOPS  = 7
) (
    input  logic [NOPS*WIDTH-1:0] res_bus,
    input  logic [NOPS-1:0]       sel,
    output logic [WIDTH-1:0]      data,
    output logic                  illegal
);

    logic [WIDTH-1:0] data_acc;
    logic             seen;
    logic             multi;

    // Gate-and-OR the slices; track whether zero, one or several bits were set
    always_comb begin
        data_acc = '0;
        seen     = 1'b0;
        multi    = 1'b0;
        for (int i = 0; i < NOPS; i++) begin
            if (sel[i]) begin
                data_acc = data_acc | res_bus[i*WIDTH +: WIDTH];
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
        illegal = !seen || multi;
        // An illegal select forwards a clean zero rather than a blend of slices
        data    = illegal ? '0 : data_acc;
    end

endmodule

// File: rtl/alu_out_stage.sv
// Registered ALU result selector with zero/neg/illegal-select flags and error counter.
// Latency: one cycle from accept to out_data when the output register is free.
// Backpressure: two-entry skid (output + skid register); in_ready depends only on state.
module alu_out_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NOPS  = NOPS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NOPS*WIDTH-1:0] res_bus,
    input  logic [NOPS-1:0]       sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_zero,
    output logic                  out_neg,
    output logic                  out_sel_err,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             xfer;
    logic             load_oreg;
    logic             load_sreg;
    logic             move_skid;

    logic [WIDTH-1:0] mux_data;
    logic             mux_err;
    logic             new_zero;
    logic             new_neg;

    logic [WIDTH-1:0] oreg_data;
    logic             oreg_zero;
    logic             oreg_neg;
    logic             oreg_err;
    logic [WIDTH-1:0] sreg_data;
    logic             sreg_zero;
    logic             sreg_neg;
    logic             sreg_err;

    onehot_sel_mux #(
        .WIDTH (WIDTH),
        .NOPS  (NOPS)
    ) u_mux (
        .res_bus (res_bus),
        .sel     (sel),
        .data    (mux_data),
        .illegal (mux_err)
    );

    // Flags are derived once at capture and travel with the word through both registers
    assign new_zero = (mux_data == '0);
    assign new_neg  = mux_data[WIDTH-1];

    // Ready comes from registered state only, so no out_ready -> in_ready path exists
    assign in_ready  = rst_n && (state != FULL2);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    assign out_data    = oreg_data;
    assign out_zero    = oreg_zero;
    assign out_neg     = oreg_neg;
    assign out_sel_err = oreg_err;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and register load steering
    always_comb begin
        state_nxt = state;
        load_oreg = 1'b0;
        load_sreg = 1'b0;
        move_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_oreg = 1'b1;
                    state_nxt = FULL1;
                end
            end
            FULL1: begin
                if (accept && xfer) begin
                    load_oreg = 1'b1;
                end else if (accept) begin
                    load_sreg = 1'b1;
                    state_nxt = FULL2;
                end else if (xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL2: begin
                if (xfer) begin
                    move_skid = 1'b1;
                    state_nxt = FULL1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Output register: new word when the head is free or leaving, else refill from skid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oreg_data <= '0;
            oreg_zero <= 1'b0;
            oreg_neg  <= 1'b0;
            oreg_err  <= 1'b0;
        end else if (load_oreg) begin
            oreg_data <= mux_data;
            oreg_zero <= new_zero;
            oreg_neg  <= new_neg;
            oreg_err  <= mux_err;
        end else if (move_skid) begin
            oreg_data <= sreg_data;
            oreg_zero <= sreg_zero;
            oreg_neg  <= sreg_neg;
            oreg_err  <= sreg_err;
        end
    end

    // Skid register catches the word accepted while the head is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_data <= '0;
            sreg_zero <= 1'b0;
            sreg_neg  <= 1'b0;
            sreg_err  <= 1'b0;
        end else if (load_sreg) begin
            sreg_data <= mux_data;
            sreg_zero <= new_zero;
            sreg_neg  <= new_neg;
            sreg_err  <= mux_err;
        end
    end

    // Saturating count of accepted words carrying an illegal select
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && mux_err && (err_count != ERR_CNT_MAX)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_out_stage.sv
// Self-checking bench for alu_out_stage: vector table, handshake corner sequences, random traffic.
// Latency: n/a.
// Backpressure: randomized out_ready against a queue-based reference model.
module tb_alu_out_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] res_bus;
    logic [6:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_zero;
    logic        out_neg;
    logic        out_sel_err;
    logic [7:0]  err_count;

    alu_out_stage #(.WIDTH(8), .NOPS(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .res_bus     (res_bus),
        .sel         (sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_sel_err (out_sel_err),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       zero;
        logic       neg;
        logic       err;
    } word_t;

    typedef struct {
        logic [6:0] sel;
        logic [7:0] exp_data;
        logic       exp_zero;
        logic       exp_neg;
        logic       exp_err;
        int         exp_cnt;
    } vec_t;

    // Slices: and=0F or=FF xor=3C not=FE add=80 sub=00 mult=7F
    localparam logic [55:0] BASE_RES = 56'h7F_00_80_FE_3C_FF_0F;

    int    total;
    int    bad;
    int    m_err;
    word_t q[$];
    vec_t  vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: exactly one select bit picks its byte; anything else is a zero error word
    function automatic word_t ref_word(input logic [6:0] s, input logic [55:0] rb);
        word_t w;
        w.err  = ($countones(s) != 1);
        w.data = 8'h00;
        if (!w.err) begin
            for (int i = 0; i < 7; i++) begin
                if (s[i]) w.data = rb[i*8 +: 8];
            end
        end
        w.zero = (w.data == 8'h00);
        w.neg  = w.data[7];
        return w;
    endfunction

    // Check visible outputs against the model, then advance one clock and update the model
    task automatic step();
        logic  acc;
        logic  xfr;
        word_t w;
        chk("in_ready", 32'(in_ready), 32'(rst_n && (q.size() < 2)));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].data));
            chk("out_zero", 32'(out_zero), 32'(q[0].zero));
            chk("out_neg", 32'(out_neg), 32'(q[0].neg));
            chk("out_sel_err", 32'(out_sel_err), 32'(q[0].err));
        end
        chk("err_count", 32'(err_count), 32'(m_err));
        acc = rst_n && in_valid && (q.size() < 2);
        xfr = (q.size() > 0) && out_ready;
        w   = ref_word(sel, res_bus);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_err = 0;
        end else begin
            if (xfr) void'(q.pop_front());
            if (acc) begin
                q.push_back(w);
                if (w.err && m_err < 255) m_err++;
            end
        end
        #1;
    endtask

    task automatic rand_res();
        res_bus[31:0]  = $urandom();
        res_bus[55:32] = 24'($urandom());
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        m_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 7'd0;
        res_bus   = BASE_RES;

        vt[0] = '{7'b0010000, 8'h80, 1'b0, 1'b1, 1'b0, 0};
        vt[1] = '{7'b0000011, 8'h00, 1'b1, 1'b0, 1'b1, 1};
        vt[2] = '{7'b0100000, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vt[3] = '{7'b1000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1};
        vt[4] = '{7'b0000000, 8'h00, 1'b1, 1'b0, 1'b1, 2};
        vt[5] = '{7'b0001000, 8'hFE, 1'b0, 1'b1, 1'b0, 2};
        vt[6] = '{7'b0000100, 8'h3C, 1'b0, 1'b0, 1'b0, 2};
        vt[7] = '{7'b1111111, 8'h00, 1'b1, 1'b0, 1'b1, 3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_flags", 32'({out_zero, out_neg, out_sel_err}), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready_high", 32'(in_ready), 32'd1);

        // Vector table: one word each, checked the cycle after acceptance
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            sel      = vt[k].sel;
            res_bus  = BASE_RES;
            step();
            in_valid = 1'b0;
            chk("vec_data", 32'(out_data), 32'(vt[k].exp_data));
            chk("vec_zero", 32'(out_zero), 32'(vt[k].exp_zero));
            chk("vec_neg", 32'(out_neg), 32'(vt[k].exp_neg));
            chk("vec_err", 32'(out_sel_err), 32'(vt[k].exp_err));
            chk("vec_cnt", 32'(err_count), 32'(vt[k].exp_cnt));
            step();
        end

        // Skid: A, B, C back to back with the output stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        res_bus   = BASE_RES;
        sel       = 7'b0000001;  // A = 0F
        step();
        sel       = 7'b0000100;  // B = 3C
        step();
        chk("skid_full_ready", 32'(in_ready), 32'd0);
        chk("skid_hold_a", 32'(out_data), 32'h0F);
        sel       = 7'b1000000;  // C = 7F, refused this cycle
        step();
        chk("skid_still_a", 32'(out_data), 32'h0F);
        out_ready = 1'b1;
        chk("skid_out_a", 32'(out_data), 32'h0F);
        step();
        chk("skid_out_b", 32'(out_data), 32'h3C);
        step();
        in_valid  = 1'b0;
        chk("skid_out_c", 32'(out_data), 32'h7F);
        chk("skid_c_valid", 32'(out_valid), 32'd1);
        step();
        chk("skid_drained", 32'(out_valid), 32'd0);

        // Full-rate rotation over all ops
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            in_valid = 1'b1;
            sel      = 7'(1 << (i % 7));
            rand_res();
            if (i > 0) chk("rot_valid", 32'(out_valid), 32'd1);
            step();
        end
        in_valid = 1'b0;
        step();

        // Random traffic with random backpressure and occasional illegal selects
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) sel = 7'($urandom());
            else sel = 7'(1 << $urandom_range(0, 6));
            rand_res();
            step();
        end

        // Reset while holding two words
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 7'b0000000;
        step();
        step();
        chk("full2_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_cnt", 32'(err_count), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Counter saturation
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 7'b0000000;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        step();
        chk("sat_cnt", 32'(err_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
